// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by the serial sequence-detector slice: the serializer
// FSM state encoding, the default word width and the pattern that the
// downstream 3-bit Moore detector looks for.
// ----------------------------------------------------------------------------
package seq_pkg;

   // Serializer state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_GAP   = ST_GAP
   } state_t;

   // Default number of bits per parallel word
   localparam int DEFAULT_WIDTH = 8;

   // Pattern recognised by the detector fed from bit_out
   localparam logic [2:0] DETECT_PATTERN = 3'b101;

endpackage

// File: rtl/seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// seq_bit_serializer
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per enabled clock on bit_out, feeding the sequence detector's input A.
// An optional idle gap follows every word, and shift_en stalls everything.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_data      parallel word to serialise (WIDTH bits)
//   in_valid     in_data is valid
//   in_ready     a word can be accepted on the coming edge
//   shift_en     advance enable; 0 freezes all state
//   bit_out      registered serial bit
//   bit_valid    bit_out carries a live data bit
//   frame_start  high with the first bit of each word
//   frame_done   high with the last bit of each word
//   busy         high while shifting or in the inter-word gap
// ----------------------------------------------------------------------------
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]   shift_reg, shift_next;
   logic               bit_out_reg, bit_out_next;
   logic               bit_valid_reg, bit_valid_next;
   logic               frame_start_reg, frame_start_next;
   logic               frame_done_reg, frame_done_next;

   logic               last_bit;
   logic               gap_last;
   logic               xfer;
   logic               load_bit, adv_bit;
   logic [WIDTH-1:0]   load_rest, adv_rest;

   assign last_bit = (cnt_reg == LAST_IDX);

   // Back-to-back reload on the last bit is only allowed without a gap.
   assign in_ready = shift_en && !reset &&
                     ((state_reg == S_IDLE) ||
                      ((state_reg == S_SHIFT) && last_bit && (GAP_CYCLES == 0)));
   assign xfer     = in_valid && in_ready;

   // The first bit goes straight to bit_out on the load edge; the shift
   // register keeps the remaining bits aligned so the next bit is always
   // at the same end.
   always_comb begin
      if (MSB_FIRST) begin
         load_bit  = in_data[WIDTH-1];
         load_rest = in_data << 1;
         adv_bit   = shift_reg[WIDTH-1];
         adv_rest  = shift_reg << 1;
      end else begin
         load_bit  = in_data[0];
         load_rest = in_data >> 1;
         adv_bit   = shift_reg[0];
         adv_rest  = shift_reg >> 1;
      end
   end

   // Gap counter exists only when a gap is configured.
   generate
      if (GAP_CYCLES > 0) begin : g_gap
         logic [3:0] gap_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               gap_reg <= '0;
            end else if (shift_en) begin
               if (state_reg == S_GAP) begin
                  gap_reg <= gap_reg + 4'd1;
               end else begin
                  gap_reg <= '0;
               end
            end
         end

         assign gap_last = (gap_reg == 4'(GAP_CYCLES - 1));
      end else begin : g_no_gap
         assign gap_last = 1'b1;
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      shift_next       = shift_reg;
      bit_out_next     = bit_out_reg;
      bit_valid_next   = bit_valid_reg;
      frame_start_next = frame_start_reg;
      frame_done_next  = frame_done_reg;

      // With shift_en low every register holds; the frame pulses are gated
      // at the outputs so they cannot repeat during a stall.
      if (shift_en) begin
         frame_start_next = 1'b0;
         frame_done_next  = 1'b0;

         case (state_reg)
            S_IDLE: begin
               bit_out_next   = 1'b0;
               bit_valid_next = 1'b0;
               if (xfer) begin
                  state_next       = S_SHIFT;
                  cnt_next         = '0;
                  shift_next       = load_rest;
                  bit_out_next     = load_bit;
                  bit_valid_next   = 1'b1;
                  frame_start_next = 1'b1;
               end
            end

            S_SHIFT: begin
               if (!last_bit) begin
                  cnt_next        = cnt_reg + CNT_W'(1);
                  shift_next      = adv_rest;
                  bit_out_next    = adv_bit;
                  frame_done_next = ((cnt_reg + CNT_W'(1)) == LAST_IDX);
               end else if (GAP_CYCLES > 0) begin
                  state_next     = S_GAP;
                  bit_out_next   = 1'b0;
                  bit_valid_next = 1'b0;
               end else if (xfer) begin
                  // Reload wins over the return to IDLE: no bubble.
                  cnt_next         = '0;
                  shift_next       = load_rest;
                  bit_out_next     = load_bit;
                  frame_start_next = 1'b1;
               end else begin
                  state_next     = S_IDLE;
                  bit_out_next   = 1'b0;
                  bit_valid_next = 1'b0;
               end
            end

            S_GAP: begin
               bit_out_next   = 1'b0;
               bit_valid_next = 1'b0;
               if (gap_last) begin
                  state_next = S_IDLE;
               end
            end

            default: begin
               state_next     = S_IDLE;
               bit_out_next   = 1'b0;
               bit_valid_next = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         shift_reg       <= '0;
         bit_out_reg     <= 1'b0;
         bit_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         shift_reg       <= shift_next;
         bit_out_reg     <= bit_out_next;
         bit_valid_reg   <= bit_valid_next;
         frame_start_reg <= frame_start_next;
         frame_done_reg  <= frame_done_next;
      end
   end

   assign bit_out     = bit_out_reg;
   assign bit_valid   = bit_valid_reg;
   assign frame_start = frame_start_reg && shift_en;
   assign frame_done  = frame_done_reg && shift_en;
   assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Four serializer configurations run side by side. Each accepted word is
// expanded into its expected bit sequence and queued; a negedge monitor
// compares the presented bits, frame markers, busy and in_ready against a
// word/gap-count view of the stream.
// ----------------------------------------------------------------------------
module tb_seq_bit_serializer;

   logic clk;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done_v [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int cfg,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, nm, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int W   = (gi == 3) ? 5 : 8;
      localparam bit MSB = (gi == 0 || gi == 2);
      localparam int GAP = (gi == 0) ? 0 : (gi == 1) ? 2 : (gi == 2) ? 3 : 1;

      typedef struct packed {
         logic b;
         logic first;
         logic last;
      } ent_t;

      logic         reset, in_valid, in_ready, shift_en;
      logic         bit_out, bit_valid, frame_start, frame_done, busy;
      logic [W-1:0] in_data;

      ent_t exp_q  [$];
      ent_t pend_q [$];
      int   gap_left = 0;
      int   qs;
      ent_t e;
      logic exp_ready;
      bit   x;

      seq_bit_serializer #(
         .WIDTH      (W),
         .MSB_FIRST  (MSB),
         .GAP_CYCLES (GAP)
      ) dut (
         .clk         (clk),
         .reset       (reset),
         .in_data     (in_data),
         .in_valid    (in_valid),
         .in_ready    (in_ready),
         .shift_en    (shift_en),
         .bit_out     (bit_out),
         .bit_valid   (bit_valid),
         .frame_start (frame_start),
         .frame_done  (frame_done),
         .busy        (busy)
      );

      // Expected serial order of a word.
      task automatic push_word(input logic [W-1:0] d);
         ent_t en;
         for (int i = 0; i < W; i++) begin
            en.b     = MSB ? d[W-1-i] : d[i];
            en.first = (i == 0);
            en.last  = (i == W - 1);
            pend_q.push_back(en);
         end
      endtask

      // One clock of stimulus; inputs change just after the rising edge.
      task automatic cyc(input logic v, input logic [W-1:0] d,
                         input logic en, output bit acc);
         @(posedge clk);
         #1;
         in_valid = v;
         in_data  = d;
         shift_en = en;
         #1;
         acc = v && in_ready && en;
         if (acc) begin
            push_word(d);
            $display("cfg%0d word %0h accepted at %0t", gi, d, $time);
         end
      endtask

      task automatic send_held(input logic [W-1:0] d);
         int k;
         bit acc;
         k   = 0;
         acc = 1'b0;
         while (!acc && k < 60) begin
            cyc(1'b1, d, 1'b1, acc);
            k++;
         end
         chk("accept_within_bound", gi, acc, 1);
      endtask

      // Reset asserted between clock edges: outputs must clear at once.
      task automatic do_reset();
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         shift_en = 1'b1;
         #2;
         reset = 1'b1;
         #1;
         chk("async_rst_bit_valid", gi, bit_valid, 0);
         chk("async_rst_bit_out",   gi, bit_out,   0);
         chk("async_rst_busy",      gi, busy,      0);
         chk("async_rst_in_ready",  gi, in_ready,  0);
         $display("cfg%0d reset pulse at %0t", gi, $time);
         @(posedge clk);
         #1;
         reset = 1'b0;
      endtask

      // Monitor / scoreboard
      always @(negedge clk) begin
         if (reset) begin
            chk("rst_bit_out",     gi, bit_out,     0);
            chk("rst_bit_valid",   gi, bit_valid,   0);
            chk("rst_frame_start", gi, frame_start, 0);
            chk("rst_frame_done",  gi, frame_done,  0);
            chk("rst_busy",        gi, busy,        0);
            chk("rst_in_ready",    gi, in_ready,    0);
            exp_q.delete();
            pend_q.delete();
            gap_left = 0;
         end else begin
            qs        = exp_q.size();
            exp_ready = shift_en && ((qs == 0 && gap_left == 0) ||
                                     (qs == 1 && GAP == 0));
            chk("in_ready",  gi, in_ready,  exp_ready);
            chk("busy",      gi, busy,      (qs > 0 || gap_left > 0));
            chk("bit_valid", gi, bit_valid, (qs > 0));
            if (qs > 0) begin
               e = exp_q[0];
               chk("bit_out",     gi, bit_out,     e.b);
               chk("frame_start", gi, frame_start, shift_en && e.first);
               chk("frame_done",  gi, frame_done,  shift_en && e.last);
               if (shift_en) begin
                  void'(exp_q.pop_front());
                  if (e.last && GAP > 0) gap_left = GAP;
               end
            end else begin
               chk("idle_bit_out",     gi, bit_out,     0);
               chk("idle_frame_start", gi, frame_start, 0);
               chk("idle_frame_done",  gi, frame_done,  0);
               if (shift_en && gap_left > 0) gap_left--;
            end
            while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
         end
      end

      // Driver
      initial begin
         reset    = 1'b1;
         in_valid = 1'b0;
         in_data  = '0;
         shift_en = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;

         // Single word, then idle
         cyc(1'b1, W'(8'hA5), 1'b1, x);
         repeat (12) cyc(1'b0, '0, 1'b1, x);

         // Back-to-back words with in_valid held
         send_held(W'(8'hFF));
         send_held(W'(8'h00));
         repeat (12) cyc(1'b0, '0, 1'b1, x);

         send_held(W'(8'h01));
         send_held(W'(8'h80));
         repeat (12) cyc(1'b0, '0, 1'b1, x);

         // Stall for three cycles in the middle of a word
         cyc(1'b1, W'(8'hC3), 1'b1, x);
         repeat (3) cyc(1'b0, '0, 1'b1, x);
         repeat (3) cyc(1'b0, '0, 1'b0, x);
         repeat (12) cyc(1'b0, '0, 1'b1, x);

         // Reset in the middle of a word, then a clean word
         cyc(1'b1, W'(8'h5A), 1'b1, x);
         repeat (4) cyc(1'b0, '0, 1'b1, x);
         do_reset();
         send_held(W'(8'h96));
         repeat (12) cyc(1'b0, '0, 1'b1, x);

         // Random traffic with stalls, dropped valids and rare resets
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
               do_reset();
            end else begin
               cyc($urandom_range(0, 3) != 0, W'($urandom),
                   $urandom_range(0, 7) != 0, x);
            end
         end
         repeat (40) cyc(1'b0, '0, 1'b1, x);
         done_v[gi] = 1'b1;
      end
   end

   initial begin
      int  t;
      bit  all_done;
      t        = 0;
      all_done = 1'b0;
      while (!all_done && t < 20000) begin
         @(posedge clk);
         t++;
         all_done = done_v[0] && done_v[1] && done_v[2] && done_v[3];
      end
      if (!all_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got %0d cycles without completion, required completion", t);
      end
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
